// File: rtl/ga_registers.sv
// Gate array CPU register file: pen/ink/border/RMR writes from Z80 I/O,
// HSYNC-aligned mode update and the 52-line raster interrupt counter.
module ga_registers (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             cen_16,
  input  logic             IORQ_N,
  input  logic             WR_N,
  input  logic             M1_N,
  input  logic             A15,
  input  logic             A14,
  input  logic [7:0]       D,
  input  logic             HSYNC,
  input  logic             VSYNC,
  output logic [15:0][4:0] INKR,
  output logic [4:0]       BORDER,
  output logic [1:0]       MODE,
  output logic             MODE_SYNC_EN,
  output logic             ROM_LO_DIS,
  output logic             ROM_HI_DIS,
  output logic             INT_N
);

  localparam logic [5:0] LINES_PER_INT = 6'd52;

  logic wr, ack;
  assign wr  = ~IORQ_N & ~WR_N & M1_N & ~A15 & A14;
  assign ack = ~IORQ_N & ~M1_N;

  // Stage 1: sample strobes/syncs and register one-tick edge pulses.
  // Bus strobe samplers reset to "active" so a strobe held through reset
  // release is not seen as a new edge.
  logic       wr_s_q, ack_s_q, hs_s_q, vs_s_q;
  logic       wr_pls_q, ack_pls_q, hs_rise_q, hs_fall_q, vs_rise_q;
  logic [7:0] dat_q;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_s_q    <= 1'b1;
      ack_s_q   <= 1'b1;
      hs_s_q    <= 1'b0;
      vs_s_q    <= 1'b0;
      wr_pls_q  <= 1'b0;
      ack_pls_q <= 1'b0;
      hs_rise_q <= 1'b0;
      hs_fall_q <= 1'b0;
      vs_rise_q <= 1'b0;
      dat_q     <= 8'h00;
    end else if (cen_16) begin
      wr_s_q    <= wr;
      ack_s_q   <= ack;
      hs_s_q    <= HSYNC;
      vs_s_q    <= VSYNC;
      wr_pls_q  <= wr & ~wr_s_q;
      ack_pls_q <= ack & ~ack_s_q;
      hs_rise_q <= HSYNC & ~hs_s_q;
      hs_fall_q <= ~HSYNC & hs_s_q;
      vs_rise_q <= VSYNC & ~vs_s_q;
      dat_q     <= D;
    end
  end

  // Stage 2: decode and apply.
  logic pen_wr, ink_wr, rmr_wr, int_clr;
  assign pen_wr  = wr_pls_q & (dat_q[7:6] == 2'b00);
  assign ink_wr  = wr_pls_q & (dat_q[7:6] == 2'b01);
  assign rmr_wr  = wr_pls_q & (dat_q[7:6] == 2'b10);
  assign int_clr = rmr_wr & dat_q[4];

  // pen_q[4] selects the border instead of an ink pen
  logic [4:0]       pen_q;
  logic [15:0][4:0] ink_q;
  logic [4:0]       border_q;
  logic [1:0]       mode_pend_q, mode_q;
  logic             msync_q, rom_lo_q, rom_hi_q;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      pen_q       <= 5'd0;
      ink_q       <= '0;
      border_q    <= 5'd0;
      mode_pend_q <= 2'd0;
      mode_q      <= 2'd0;
      msync_q     <= 1'b0;
      rom_lo_q    <= 1'b0;
      rom_hi_q    <= 1'b0;
    end else if (cen_16) begin
      if (pen_wr)
        pen_q <= dat_q[4] ? 5'b1_0000 : {1'b0, dat_q[3:0]};
      if (ink_wr) begin
        if (pen_q[4]) border_q <= dat_q[4:0];
        else          ink_q[pen_q[3:0]] <= dat_q[4:0];
      end
      if (rmr_wr) begin
        mode_pend_q <= dat_q[1:0];
        rom_lo_q    <= dat_q[2];
        rom_hi_q    <= dat_q[3];
      end
      // MODE only moves at line start so a line never mixes two modes
      msync_q <= hs_rise_q;
      if (hs_rise_q)
        mode_q <= mode_pend_q;
    end
  end

  // Raster interrupt counter with VSYNC resynchronisation.
  logic [5:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] dly_q, dly_d;
  logic       int_n_q, int_n_d, int_raise;

  assign cnt_inc = cnt_q + 6'd1;

  always_comb begin
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    int_n_d   = int_n_q;
    int_raise = 1'b0;
    if (hs_fall_q) begin
      if (dly_q == 2'd1) begin
        cnt_d = 6'd0;
        dly_d = 2'd0;
        if (cnt_inc == LINES_PER_INT || cnt_q[5]) int_raise = 1'b1;
      end else begin
        if (dly_q == 2'd2) dly_d = 2'd1;
        if (cnt_inc == LINES_PER_INT) begin
          cnt_d     = 6'd0;
          int_raise = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
    if (vs_rise_q) dly_d = 2'd2;
    if (int_raise) begin
      int_n_d = 1'b0;
    end else if (ack_pls_q && !int_n_q) begin
      int_n_d  = 1'b1;
      cnt_d[5] = 1'b0;
    end
    if (int_clr) begin
      cnt_d   = 6'd0;
      int_n_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q   <= 6'd0;
      dly_q   <= 2'd0;
      int_n_q <= 1'b1;
    end else if (cen_16) begin
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      int_n_q <= int_n_d;
    end
  end

  assign INKR         = ink_q;
  assign BORDER       = border_q;
  assign MODE         = mode_q;
  assign MODE_SYNC_EN = msync_q;
  assign ROM_LO_DIS   = rom_lo_q;
  assign ROM_HI_DIS   = rom_hi_q;
  assign INT_N        = int_n_q;

endmodule

// File: tb/tb_ga_registers.sv
// Scoreboard bench for ga_registers: expectations are queued as stimulus is
// applied and compared against DUT outputs once the latency has elapsed.
module tb_ga_registers;

  logic             clk = 1'b0;
  logic             RESET_N = 1'b0;
  logic             cen_16 = 1'b0;
  logic             IORQ_N = 1'b1, WR_N = 1'b1, M1_N = 1'b1;
  logic             A15 = 1'b0, A14 = 1'b1;
  logic [7:0]       D = 8'h00;
  logic             HSYNC = 1'b0, VSYNC = 1'b0;
  logic [15:0][4:0] INKR;
  logic [4:0]       BORDER;
  logic [1:0]       MODE;
  logic             MODE_SYNC_EN, ROM_LO_DIS, ROM_HI_DIS, INT_N;

  ga_registers dut (
    .clk(clk), .RESET_N(RESET_N), .cen_16(cen_16),
    .IORQ_N(IORQ_N), .WR_N(WR_N), .M1_N(M1_N), .A15(A15), .A14(A14), .D(D),
    .HSYNC(HSYNC), .VSYNC(VSYNC),
    .INKR(INKR), .BORDER(BORDER), .MODE(MODE), .MODE_SYNC_EN(MODE_SYNC_EN),
    .ROM_LO_DIS(ROM_LO_DIS), .ROM_HI_DIS(ROM_HI_DIS), .INT_N(INT_N)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cen_16 <= ~cen_16;

  typedef enum int {S_INK, S_BORDER, S_MODE, S_MSYNC, S_ROMLO, S_ROMHI, S_INTN, S_CNT} sel_e;
  typedef struct {
    string      tag;
    sel_e       sel;
    int         idx;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_of(input sel_e sel, input int idx);
    case (sel)
      S_INK:    return {3'b0, INKR[idx]};
      S_BORDER: return {3'b0, BORDER};
      S_MODE:   return {6'b0, MODE};
      S_MSYNC:  return {7'b0, MODE_SYNC_EN};
      S_ROMLO:  return {7'b0, ROM_LO_DIS};
      S_ROMHI:  return {7'b0, ROM_HI_DIS};
      S_INTN:   return {7'b0, INT_N};
      default:  return {2'b0, dut.cnt_q};
    endcase
  endfunction

  task automatic expect_v(input string tag, input sel_e sel, input int idx, input logic [7:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.idx = idx; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, obs_of(e.sel, e.idx), e.val);
    end
  endtask

  // Two clk edges always contain exactly one cen_16-active edge.
  task automatic tick(input int n);
    repeat (2 * n) @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] d);
    D = d; IORQ_N = 1'b0; WR_N = 1'b0; M1_N = 1'b1; A15 = 1'b0; A14 = 1'b1;
    tick(1);
    IORQ_N = 1'b1; WR_N = 1'b1;
    tick(1);
  endtask

  task automatic int_ack();
    IORQ_N = 1'b0; M1_N = 1'b0;
    tick(1);
    IORQ_N = 1'b1; M1_N = 1'b1;
    tick(1);
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      HSYNC = 1'b1; tick(2);
      HSYNC = 1'b0; tick(2);
    end
  endtask

  task automatic vsync_pulse();
    VSYNC = 1'b1; tick(2);
    VSYNC = 1'b0; tick(1);
  endtask

  task automatic expect_int(input string tag, input logic intn, input int cnt);
    expect_v({tag, "_intn"}, S_INTN, 0, {7'b0, intn});
    expect_v({tag, "_cnt"},  S_CNT,  0, 8'(cnt));
    drain();
  endtask

  initial begin
    tick(3);
    RESET_N = 1'b1;
    tick(2);

    for (int p = 0; p < 16; p++) expect_v($sformatf("rst_ink%0d", p), S_INK, p, 8'h00);
    expect_v("rst_border", S_BORDER, 0, 8'h00);
    expect_v("rst_mode",   S_MODE,   0, 8'h00);
    expect_v("rst_msync",  S_MSYNC,  0, 8'h00);
    expect_v("rst_romlo",  S_ROMLO,  0, 8'h00);
    expect_v("rst_romhi",  S_ROMHI,  0, 8'h00);
    expect_v("rst_intn",   S_INTN,   0, 8'h01);
    expect_v("rst_cnt",    S_CNT,    0, 8'h00);
    drain();

    io_write(8'h03); io_write(8'h4A); io_write(8'h10); io_write(8'h55);
    io_write(8'h0F); io_write(8'h5F);
    io_write(8'hDF);  // top-bits 11: ignored
    for (int p = 0; p < 16; p++)
      expect_v($sformatf("ink%0d", p), S_INK, p, (p == 3) ? 8'h0A : (p == 15) ? 8'h1F : 8'h00);
    expect_v("border", S_BORDER, 0, 8'h15);
    expect_v("ign_romlo", S_ROMLO, 0, 8'h00);
    drain();

    // RMR write mid-line: ROM bits after two ticks, MODE waits for HSYNC.
    D = 8'h8E; IORQ_N = 1'b0; WR_N = 1'b0;
    tick(1);
    IORQ_N = 1'b1; WR_N = 1'b1;
    expect_v("romlo_early", S_ROMLO, 0, 8'h00);
    drain();
    tick(1);
    expect_v("romlo", S_ROMLO, 0, 8'h01);
    expect_v("romhi", S_ROMHI, 0, 8'h01);
    expect_v("mode_hold", S_MODE, 0, 8'h00);
    drain();
    tick(3);
    expect_v("mode_hold2", S_MODE, 0, 8'h00);
    drain();
    HSYNC = 1'b1; tick(1);
    expect_v("mode_lat1", S_MODE, 0, 8'h00);
    expect_v("msync_lat1", S_MSYNC, 0, 8'h00);
    drain();
    tick(1);
    expect_v("mode_upd", S_MODE, 0, 8'h02);
    expect_v("msync_pulse", S_MSYNC, 0, 8'h01);
    drain();
    tick(1);
    expect_v("msync_end", S_MSYNC, 0, 8'h00);
    expect_v("mode_keep", S_MODE, 0, 8'h02);
    drain();
    HSYNC = 1'b0; tick(2);
    expect_int("line1", 1'b1, 1);

    io_write(8'h9E);
    expect_int("rmr_clr", 1'b1, 0);

    lines(51);  expect_int("l51", 1'b1, 51);
    lines(1);   expect_int("l52", 1'b0, 0);
    lines(8);   expect_int("l60", 1'b0, 8);
    int_ack();  expect_int("ack8", 1'b1, 8);
    lines(43);  expect_int("l103", 1'b1, 51);
    lines(1);   expect_int("l104", 1'b0, 0);

    lines(40);  expect_int("c40", 1'b0, 40);
    int_ack();  expect_int("ack40", 1'b1, 8);
    int_ack();  expect_int("ack_idle", 1'b1, 8);
    lines(12);  expect_int("c20", 1'b1, 20);
    vsync_pulse();
    lines(1);   expect_int("vs20_1", 1'b1, 21);
    lines(1);   expect_int("vs20_2", 1'b1, 0);

    lines(35);  expect_int("c35", 1'b1, 35);
    vsync_pulse();
    lines(1);   expect_int("vs35_1", 1'b1, 36);
    lines(1);   expect_int("vs35_2", 1'b0, 0);
    int_ack();  expect_int("ack0", 1'b1, 0);

    // D4 reset on the same tick as the 52nd HSYNC fall
    lines(51);  expect_int("pre_coin", 1'b1, 51);
    HSYNC = 1'b1; tick(2);
    HSYNC = 1'b0; D = 8'h90; IORQ_N = 1'b0; WR_N = 1'b0;
    tick(1);
    IORQ_N = 1'b1; WR_N = 1'b1;
    tick(1);
    expect_int("coin", 1'b1, 0);
    expect_v("coin_romlo", S_ROMLO, 0, 8'h00);
    drain();

    // Held strobe: one write only, later D changes are ignored.
    io_write(8'h00);
    D = 8'h41; IORQ_N = 1'b0; WR_N = 1'b0;
    tick(5);
    D = 8'h47;
    tick(15);
    IORQ_N = 1'b1; WR_N = 1'b1;
    tick(2);
    expect_v("held_ink0", S_INK, 0, 8'h01);
    drain();

    // Strobe held low across reset release: no write.
    D = 8'h5F; IORQ_N = 1'b0; WR_N = 1'b0;
    tick(1);
    RESET_N = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(4);
    expect_v("rst_held_ink0", S_INK, 0, 8'h00);
    expect_v("rst_held_border", S_BORDER, 0, 8'h00);
    drain();
    IORQ_N = 1'b1; WR_N = 1'b1;
    tick(2);
    expect_v("rst_rel_ink0", S_INK, 0, 8'h00);
    drain();
    io_write(8'h5F);
    expect_v("post_rst_ink0", S_INK, 0, 8'h1F);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
